// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's-complement.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN: finish on the first differing digit.
module seq_mag_comparator #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             ls
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = $clog2(N + 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [CNT_W-1:0] cnt_r;
   logic             undecided_r;
   logic             gt_r;

   logic [DIGIT-1:0] dig_a_s;
   logic [DIGIT-1:0] dig_b_s;
   logic             differ_s;
   logic             undecided_nxt_s;
   logic             gt_nxt_s;
   logic             last_s;
   logic             finish_s;
   logic [WIDTH-1:0] msb_flip_s;

   // Current-digit decision and end-of-scan detection
   always_comb begin
      dig_a_s         = sh_a_r[WIDTH-1 -: DIGIT];
      dig_b_s         = sh_b_r[WIDTH-1 -: DIGIT];
      differ_s        = (dig_a_s != dig_b_s);
      undecided_nxt_s = undecided_r;
      gt_nxt_s        = gt_r;
      if (undecided_r && differ_s) begin
         undecided_nxt_s = 1'b0;
         gt_nxt_s        = (dig_a_s > dig_b_s);
      end else begin
         undecided_nxt_s = undecided_r;
         gt_nxt_s        = gt_r;
      end
      last_s = (cnt_r == CNT_W'(N - 1));
`ifdef SEQ_CMP_EARLY_EXIT_EN
      finish_s = last_s || (undecided_r && differ_s);
`else
      finish_s = last_s;
`endif
      // Offset-binary: flipping both sign bits turns a signed compare into an unsigned one
      msb_flip_s = {signed_mode, {(WIDTH-1){1'b0}}};
   end

   // Control FSM, operand shift registers and registered result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         sh_a_r      <= '0;
         sh_b_r      <= '0;
         cnt_r       <= '0;
         undecided_r <= 1'b0;
         gt_r        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         gt          <= 1'b0;
         eq          <= 1'b0;
         ls          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  sh_a_r      <= a ^ msb_flip_s;
                  sh_b_r      <= b ^ msb_flip_s;
                  cnt_r       <= '0;
                  undecided_r <= 1'b1;
                  gt_r        <= 1'b0;
                  busy        <= 1'b1;
                  state_r     <= SCAN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SCAN: begin
               sh_a_r      <= sh_a_r << DIGIT;
               sh_b_r      <= sh_b_r << DIGIT;
               cnt_r       <= cnt_r + CNT_W'(1);
               undecided_r <= undecided_nxt_s;
               gt_r        <= gt_nxt_s;
               if (finish_s) begin
                  gt      <= ~undecided_nxt_s & gt_nxt_s;
                  ls      <= ~undecided_nxt_s & ~gt_nxt_s;
                  eq      <= undecided_nxt_s;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy    <= 1'b1;
                  state_r <= SCAN;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench: vector table, hand sequences, random ops vs arithmetic model,
// exhaustive 4-bit sweeps with DIGIT=1 and DIGIT=4.
module tb_seq_mag_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, signed_mode = 1'b0;
   logic [7:0] a = 8'h00, b = 8'h00;
   logic       busy, done, gt, eq, ls;

   logic       start4 = 1'b0, sm4 = 1'b0;
   logic [3:0] a4 = 4'h0, b4 = 4'h0;
   logic       busy1, done1, gt1, eq1, ls1;
   logic       busy4, done4, gt4, eq4, ls4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .ls(ls));

   seq_mag_comparator #(.WIDTH(4), .DIGIT(1)) dut_d1 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .ls(ls1));

   seq_mag_comparator #(.WIDTH(4), .DIGIT(4)) dut_d4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .ls(ls4));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      logic [2:0] flags;   // {gt,eq,ls}
      int         lat_d;
      int         lat_e;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: interpret operands as integers and compare
   function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y,
                                            input int w, input logic sm);
      int vx, vy, m;
      m  = (1 << w) - 1;
      vx = int'(x) & m;
      vy = int'(y) & m;
      if (sm && vx >= (1 << (w - 1))) vx -= (1 << w);
      if (sm && vy >= (1 << (w - 1))) vy -= (1 << w);
      if (vx > vy) return 3'b100;
      else if (vx == vy) return 3'b010;
      else return 3'b001;
   endfunction

   // Early-exit latency: number of MSB-first digits needed before prefixes differ
   function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
      if (!EARLY) return 4;
      for (int i = 0; i < 4; i++) begin
         if ((x >> (8 - 2 * (i + 1))) != (y >> (8 - 2 * (i + 1)))) return i + 1;
      end
      return 4;
   endfunction

   task automatic wait_done(output int lat, output bit seen, output bit held);
      logic [2:0] prev;
      prev = {gt, eq, ls};
      seen = 1'b0;
      held = 1'b1;
      lat  = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk); #1;
         lat++;
         if (done) seen = 1'b1;
         else if ({gt, eq, ls} !== prev) held = 1'b0;
      end
   endtask

   task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic sm, input logic [2:0] exp_f, input int exp_lat);
      int lat; bit seen, held;
      @(negedge clk);
      a = ta; b = tb_; signed_mode = sm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      wait_done(lat, seen, held);
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_flags"}, 32'({gt, eq, ls}), 32'(exp_f));
      chk({nm, "_hold_while_busy"}, 32'(held), 32'd1);
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int lat; bit seen, held; bit got1, got4;
      logic [2:0] f1, f4, ef;
      logic [7:0] ra, rb; logic rs;

      vecs[0] = '{8'hF0, 8'h0F, 1'b0, 3'b100, 4, 1};
      vecs[1] = '{8'hF0, 8'h0F, 1'b1, 3'b001, 4, 1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 3'b001, 4, 1};
      vecs[3] = '{8'h80, 8'h7F, 1'b0, 3'b100, 4, 1};
      vecs[4] = '{8'h41, 8'h42, 1'b0, 3'b001, 4, 4};
      vecs[5] = '{8'h12, 8'h12, 1'b0, 3'b010, 4, 4};
      vecs[6] = '{8'h00, 8'h01, 1'b1, 3'b001, 4, 4};
      vecs[7] = '{8'h05, 8'h03, 1'b0, 3'b100, 4, 3};

      #12;
      chk("reset_outputs", 32'({busy, done, gt, eq, ls}), 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].flags,
               EARLY ? vecs[i].lat_e : vecs[i].lat_d);

      // Reset asserted mid-SCAN clears everything immediately and suppresses done
      @(negedge clk); a = 8'h41; b = 8'h42; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1; #1;
      chk("rst_mid_scan", 32'({busy, done, gt, eq, ls}), 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      chk("no_done_after_abort", 32'(seen), 32'd0);
      do_op("post_reset_eq", 8'h12, 8'h12, 1'b0, 3'b010, 4);

      // start while busy is ignored
      @(negedge clk); a = 8'h41; b = 8'h42; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; a = 8'hFF; b = 8'h00; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("ignore_start_busy", 32'(busy), 32'd1);
      wait_done(lat, seen, held);
      chk("ignore_start_done", 32'(seen), 32'd1);
      chk("ignore_start_latency", 32'(lat + 2), 32'd4);
      chk("ignore_start_flags", 32'({gt, eq, ls}), 32'b001);

      // Back-to-back: start held high through DONE
      @(negedge clk); a = 8'hF0; b = 8'h0F; signed_mode = 1'b1; start = 1'b1;
      @(posedge clk); #1; a = 8'h05; b = 8'h03; signed_mode = 1'b0;
      wait_done(lat, seen, held);
      chk("b2b_first_done", 32'(seen), 32'd1);
      chk("b2b_first_flags", 32'({gt, eq, ls}), 32'b001);
      @(posedge clk); #1; start = 1'b0;
      chk("b2b_accepted", 32'({busy, done}), 32'b10);
      chk("b2b_flags_held", 32'({gt, eq, ls}), 32'b001);
      wait_done(lat, seen, held);
      chk("b2b_second_done", 32'(seen), 32'd1);
      chk("b2b_second_latency", 32'(lat), 32'(EARLY ? 3 : 4));
      chk("b2b_second_flags", 32'({gt, eq, ls}), 32'b100);
      chk("b2b_hold", 32'(held), 32'd1);

      // Random operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom); rb = (i % 4 == 0) ? ra : 8'($urandom); rs = 1'($urandom);
         do_op($sformatf("rand%0d", i), ra, rb, rs, ref_flags(ra, rb, 8, rs), ref_lat(ra, rb));
      end

      // Exhaustive 4-bit sweep, both modes, DIGIT=1 and DIGIT=4
      for (int m = 0; m < 2; m++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
               @(negedge clk);
               a4 = 4'(x); b4 = 4'(y); sm4 = 1'(m); start4 = 1'b1;
               @(posedge clk); #1; start4 = 1'b0;
               got1 = 1'b0; got4 = 1'b0; f1 = 3'b000; f4 = 3'b000;
               for (int k = 0; k < 10 && !(got1 && got4); k++) begin
                  @(posedge clk); #1;
                  if (done1 && !got1) begin got1 = 1'b1; f1 = {gt1, eq1, ls1}; end
                  if (done4 && !got4) begin got4 = 1'b1; f4 = {gt4, eq4, ls4}; end
               end
               ef = ref_flags(8'(x), 8'(y), 4, 1'(m));
               chk($sformatf("sweep_d1_done m%0d %0d/%0d", m, x, y), 32'(got1), 32'd1);
               chk($sformatf("sweep_d4_done m%0d %0d/%0d", m, x, y), 32'(got4), 32'd1);
               chk($sformatf("sweep_d1 m%0d %0d/%0d", m, x, y), 32'(f1), 32'(ef));
               chk($sformatf("sweep_d4 m%0d %0d/%0d", m, x, y), 32'(f4), 32'(ef));
               chk($sformatf("sweep_onehot m%0d %0d/%0d", m, x, y),
                   32'({$onehot(f1), $onehot(f4)}), 32'b11);
            end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
